// File: rtl/spi_master.sv
// SPI Mode 0 master: shifts one command frame out on MOSI (MSB first) while
// capturing the reply on MISO. SCLK and CS are generated from sysclk.
module spi_master #(
  parameter int unsigned FRAME_WIDTH = 24,
  parameter int unsigned CLK_DIV     = 4
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [7:0]             i_cmd,
  input  logic [7:0]             i_addr,
  input  logic [7:0]             i_payload,
  input  logic                   miso,
  output logic                   sclk,
  output logic                   cs,
  output logic                   mosi,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [FRAME_WIDTH-1:0] o_rx_frame
);

  localparam int unsigned PHASE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_WIDTH);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                  state_q, state_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [FRAME_WIDTH-1:0]  tx_q, tx_d;
  logic [FRAME_WIDTH-1:0]  rx_q, rx_d;
  logic                    miso_q;
  logic                    sclk_d, cs_d, mosi_d, busy_d, done_d;
  logic [FRAME_WIDTH-1:0]  rx_frame_d;
  logic [FRAME_WIDTH-1:0]  start_frame;
  logic                    phase_wrap;

  assign start_frame = FRAME_WIDTH'({i_cmd, i_addr, i_payload});
  assign phase_wrap  = (phase_q == PHASE_LAST);

  // State and output registers
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      miso_q     <= 1'b0;
      sclk       <= 1'b0;
      cs         <= 1'b1;
      mosi       <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rx_frame <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      miso_q     <= miso;
      sclk       <= sclk_d;
      cs         <= cs_d;
      mosi       <= mosi_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
      o_rx_frame <= rx_frame_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    sclk_d     = sclk;
    cs_d       = cs;
    mosi_d     = mosi;
    busy_d     = o_busy;
    done_d     = 1'b0;
    rx_frame_d = o_rx_frame;

    case (state_q)
      IDLE: begin
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        phase_d = '0;
        bit_d   = '0;
        if (i_start) begin
          tx_d    = start_frame;
          mosi_d  = start_frame[FRAME_WIDTH-1];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        phase_d = phase_q + PHASE_W'(1);
        if (phase_wrap) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        phase_d = phase_q + PHASE_W'(1);
        if (phase_wrap) begin
          phase_d = '0;
          if (sclk) begin
            // Falling edge: capture MISO at the end of the high phase, advance MOSI
            sclk_d = 1'b0;
            rx_d   = {rx_q[FRAME_WIDTH-2:0], miso_q};
            tx_d   = tx_q << 1;
            if (bit_q == BIT_LAST) begin
              mosi_d  = 1'b0;
              bit_d   = '0;
              state_d = HOLD;
            end else begin
              mosi_d = tx_q[FRAME_WIDTH-2];
              bit_d  = bit_q + BIT_W'(1);
            end
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      HOLD: begin
        phase_d = phase_q + PHASE_W'(1);
        if (phase_wrap) begin
          phase_d    = '0;
          cs_d       = 1'b1;
          done_d     = 1'b1;
          rx_frame_d = rx_q;
          state_d    = GAP;
        end
      end
      GAP: begin
        phase_d = phase_q + PHASE_W'(1);
        if (phase_wrap) begin
          phase_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: vector table, a MISO slave model and a
// scoreboard of expected MOSI/RX frames compared at each o_done.
module tb_spi_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FW      = 24;

  logic          sysclk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [7:0]    i_cmd, i_addr, i_payload;
  logic          miso;
  logic          sclk, cs, mosi, o_busy, o_done;
  logic [FW-1:0] o_rx_frame;

  spi_master #(.FRAME_WIDTH(FW), .CLK_DIV(CLK_DIV)) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .i_start    (i_start),
    .i_cmd      (i_cmd),
    .i_addr     (i_addr),
    .i_payload  (i_payload),
    .miso       (miso),
    .sclk       (sclk),
    .cs         (cs),
    .mosi       (mosi),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_rx_frame (o_rx_frame)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [23:0] tx;
    logic [23:0] rx;
  } exp_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [7:0]  pay;
    logic [23:0] slv;
    logic [23:0] exp_tx;
    logic [23:0] exp_rx;
  } vec_t;

  exp_t sb[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rise_cnt = 0;
  int cs_rise_cyc = 0;
  int cs_high_len = 0;
  int busy_fall_cyc = 0;
  int busy_low_len = 0;
  int slv_wait = 0;
  logic [23:0] mosi_cap = '0;
  logic [23:0] slv_frame = '0;
  logic [23:0] slv_sr = '0;
  logic prev_sclk = 1'b0;
  logic prev_cs = 1'b1;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor, slave model and scoreboard, sampled 1ns after each sysclk edge
  initial begin
    miso = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      cyc++;
      if (slv_wait > 0) begin
        slv_wait--;
        if (slv_wait == 0) begin
          slv_sr = slv_sr << 1;
          miso   = slv_sr[23];
        end
      end
      if (prev_cs === 1'b1 && cs === 1'b0) begin
        slv_sr      = slv_frame;
        miso        = slv_sr[23];
        rise_cnt    = 0;
        mosi_cap    = '0;
        cs_high_len = cyc - cs_rise_cyc;
      end
      if (prev_cs === 1'b0 && cs === 1'b1) cs_rise_cyc = cyc;
      if (prev_sclk === 1'b0 && sclk === 1'b1) begin
        rise_cnt++;
        mosi_cap = {mosi_cap[22:0], mosi};
      end
      if (prev_sclk === 1'b1 && sclk === 1'b0 && cs === 1'b0) slv_wait = 3;
      if (prev_busy === 1'b1 && o_busy === 1'b0) busy_fall_cyc = cyc;
      if (prev_busy === 1'b0 && o_busy === 1'b1) busy_low_len = cyc - busy_fall_cyc;
      if (o_done === 1'b1) begin
        exp_t e;
        done_cnt++;
        done_cyc = cyc;
        check("sb_pending", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rx_frame", o_rx_frame, e.rx);
          check("mosi_frame", mosi_cap, e.tx);
          check("sclk_rises", rise_cnt, 24);
        end
      end
      prev_sclk = sclk;
      prev_cs   = cs;
      prev_busy = o_busy;
    end
  end

  task automatic start_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p,
                             input logic [23:0] slv, output int sc);
    exp_t e;
    @(negedge sysclk);
    i_cmd     = c;
    i_addr    = a;
    i_payload = p;
    slv_frame = slv;
    i_start   = 1'b1;
    e.tx = {c, a, p};
    e.rx = slv;
    sb.push_back(e);
    sc = cyc + 1;
    @(negedge sysclk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 1000) begin
      @(negedge sysclk);
      k++;
    end
    check("done_seen", 32'(done_cnt >= target), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int sc, t, d1, d2, k;

    vecs[0] = '{8'h01, 8'h02, 8'h80, 24'h000000, 24'h010280, 24'h000000};
    vecs[1] = '{8'h3C, 8'h5A, 8'h0F, 24'hA5C3F0, 24'h3C5A0F, 24'hA5C3F0};
    vecs[2] = '{8'hFF, 8'h00, 8'hAA, 24'h123456, 24'hFF00AA, 24'h123456};
    vecs[3] = '{8'h00, 8'h00, 8'h01, 24'hFFFFFF, 24'h000001, 24'hFFFFFF};

    rst = 1'b0;
    i_start = 1'b0;
    i_cmd = '0;
    i_addr = '0;
    i_payload = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge sysclk);
    check("rst_sclk", sclk, 0);
    check("rst_cs", cs, 1);
    check("rst_mosi", mosi, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_rx_frame", o_rx_frame, 0);
    rst = 1'b0;
    repeat (2) @(negedge sysclk);

    // Table-driven single frames
    for (int i = 0; i < 4; i++) begin
      t = done_cnt;
      start_frame(vecs[i].cmd, vecs[i].addr, vecs[i].pay, vecs[i].slv, sc);
      sb[sb.size()-1].tx = vecs[i].exp_tx;
      sb[sb.size()-1].rx = vecs[i].exp_rx;
      wait_done(t + 1);
      check("latency", done_cyc - sc, 49 * CLK_DIV);
      check("done_high", o_done, 1);
      check("cs_at_done", cs, 1);
      check("mosi_after_frame", mosi, 0);
      @(negedge sysclk);
      check("done_pulse_end", o_done, 0);
      repeat (2) @(negedge sysclk);
      check("busy_in_gap", o_busy, 1);
      @(negedge sysclk);
      check("busy_released", o_busy, 0);
      repeat (3) @(negedge sysclk);
    end

    // Start while busy is ignored, and late data changes do not leak in
    t = done_cnt;
    start_frame(8'h12, 8'h34, 8'h56, 24'h654321, sc);
    repeat (49) @(negedge sysclk);
    i_cmd = 8'hFF;
    i_addr = 8'hFF;
    i_payload = 8'hFF;
    i_start = 1'b1;
    @(negedge sysclk);
    i_start = 1'b0;
    wait_done(t + 1);
    repeat (30) @(negedge sysclk);
    check("busy_start_no_extra_done", done_cnt, t + 1);
    check("busy_start_cs_idle", cs, 1);
    check("busy_start_idle", o_busy, 0);

    // Back-to-back frames with i_start held high
    t = done_cnt;
    @(negedge sysclk);
    i_cmd = 8'h0A;
    i_addr = 8'h0B;
    i_payload = 8'h0C;
    slv_frame = 24'h5A5A5A;
    begin
      exp_t e;
      e.tx = 24'h0A0B0C;
      e.rx = 24'h5A5A5A;
      sb.push_back(e);
      sb.push_back(e);
    end
    i_start = 1'b1;
    wait_done(t + 1);
    d1 = done_cyc;
    wait_done(t + 2);
    i_start = 1'b0;
    d2 = done_cyc;
    check("b2b_done_spacing", d2 - d1, 50 * CLK_DIV + 1);
    check("b2b_cs_high", cs_high_len, CLK_DIV + 1);
    check("b2b_busy_low", busy_low_len, 1);
    repeat (20) @(negedge sysclk);
    check("b2b_no_third", done_cnt, t + 2);
    check("b2b_idle", o_busy, 0);

    // Reset mid-frame after the 10th SCLK rising edge
    t = done_cnt;
    start_frame(8'hC3, 8'h3C, 8'h99, 24'hFEDCBA, sc);
    k = 0;
    while (rise_cnt < 10 && k < 400) begin
      @(negedge sysclk);
      k++;
    end
    check("reach_rise10", rise_cnt, 10);
    rst = 1'b1;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_mosi", mosi, 0);
    check("abort_busy", o_busy, 0);
    check("abort_rx_frame", o_rx_frame, 0);
    sb.delete();
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    repeat (250) @(negedge sysclk);
    check("abort_no_done", done_cnt, t);
    check("abort_rx_hold", o_rx_frame, 0);

    // Fresh frame after reset release
    t = done_cnt;
    start_frame(8'h01, 8'h03, 8'h40, 24'h00FF00, sc);
    wait_done(t + 1);
    check("post_reset_latency", done_cyc - sc, 49 * CLK_DIV);
    repeat (10) @(negedge sysclk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
